prog_loader: RTL and testbench
==============================

# prog_loader

Instruction-store responder for the 4-bit CPU. Holds the 16×8 program that the CPU fetches by driving `adr` and sampling `dout`. Accepts a new program over a byte-wide valid/ready load port, checks it against a trailing 8-bit additive checksum, and holds the CPU in reset through its active-low `reset` input until a verified image is present.

## Interface
- `AW`, 4, fetch address width; depth is 2^AW = 16 words.
- `DW`, 8, instruction width.
- `clk`  in  1  system clock, shared with the CPU.
- `reset`  in  1  asynchronous, active-low block reset.
- `adr`  in  AW  fetch address from the CPU program counter.
- `dout`  out  DW  instruction at `adr`.
- `ld_start`  in  1  one-cycle request to begin a new load.
- `ld_valid`  in  1  `ld_data` is valid.
- `ld_data`  in  DW  program byte, or the checksum byte.
- `ld_ready`  out  1  block accepts `ld_data` this cycle.
- `cpu_reset`  out  1  drives the CPU `reset` port; 0 holds the CPU in reset.
- `load_done`  out  1  one-cycle pulse when a load verifies.
- `load_err`  out  1  sticky checksum-mismatch flag.

## Operation
- Memory is 16×8. Read is combinational: `dout = mem[adr]` in every state, with no fetch latency. The CPU samples it on the same edge.
- States:
  - RUN: `cpu_reset`=1, `ld_ready`=0. `ld_valid` is ignored.
  - LOAD: `cpu_reset`=0, `ld_ready`=1. A handshake (`ld_valid & ld_ready`) writes `mem[waddr]=ld_data`, adds to the checksum (`sum += ld_data`, mod 256) and increments `waddr`. The handshake that writes `waddr`=15 moves the FSM to CHECK.
  - CHECK: `cpu_reset`=0, `ld_ready`=1. On handshake, compare `ld_data` with `sum`:
    - equal: go to RUN and pulse `load_done`.
    - not equal: go to ERR and set `load_err`=1.
  - ERR: `cpu_reset`=0, `ld_ready`=0, `load_err`=1. Exits only on `ld_start`.
- `ld_start` in any state moves the FSM to LOAD with `waddr`=0, `sum`=0 and `load_err`=0.
  - If `ld_start` and `ld_valid` are high in the same cycle, start wins and the byte is dropped.
  - `ld_start` during LOAD or CHECK restarts the load. Words already written stay in memory; the CPU remains in reset.
- Arithmetic:
  - `waddr` is AW bits and wraps 15→0.
  - `sum` is DW bits and wraps mod 256. The checksum byte itself is not added.
- A failed image stays in memory but is never run.

## Timing
- Reset (async assert) drives:
  - state = RUN, `cpu_reset`=1;
  - all 16 words = 0x00 (MOV r0,r0, a no-op);
  - `waddr`=0, `sum`=0;
  - `ld_ready`=0, `load_done`=0, `load_err`=0.
- Reset deassert takes effect on the next `clk` edge.
- `ld_start` sampled at edge N: `cpu_reset`=0 and `ld_ready`=1 from N+1.
- A write accepted at edge N is visible on `dout` from N+1.
- Matching checksum accepted at edge N: `cpu_reset`=1 and `load_done`=1 during N+1; `load_done`=0 from N+2.
- The fastest complete load is 17 handshakes, so `cpu_reset` releases no earlier than 18 cycles after `ld_start`.
- All outputs except `dout` are registered. `ld_ready` is a function of state only and never depends on `ld_valid`.

## Structure
- Shared package `prog_loader_pkg`:
  - state enum {RUN, LOAD, CHECK, ERR};
  - `MEM_DEPTH`=16;
  - `NOP_INSN`=8'h00.
- One sub-module, `prog_mem_16x8`: async-reset register array with one synchronous write port and one combinational read port.
- FSM, address counter and checksum live in `prog_loader`.

## Test plan
1. Reset, then sweep `adr` 0..15 → `dout`=0x00 everywhere; `cpu_reset`=1; `ld_ready`=0.
2. `ld_start`, then bytes 0x01..0x10, then checksum 0x88 → `load_done` pulses once; `cpu_reset`=1 the cycle after; `mem[k]`=k+1.
3. Same 16 bytes with checksum 0x87 → `load_err`=1, `cpu_reset` stays 0, `ld_ready`=0. A new `ld_start` clears `load_err` on the next cycle.
4. `ld_valid` toggled on alternate cycles during a load → only handshake cycles write; the final image and `load_done` are identical to scenario 2.
5. `ld_start` after 7 bytes, then a full load of 0xA1×16 with checksum 0x10 → `load_done`; `mem[0..15]`=0xA1; `waddr` restarted at 0.
6. Async reset asserted mid-LOAD (byte 9) → next cycle all outputs are at reset values and memory reads 0x00; `ld_start` and `ld_valid` together → state LOAD, byte not written.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader and its instruction store.
package prog_loader_pkg;

    localparam int unsigned  MEM_DEPTH = 16;
    localparam logic [7:0]   NOP_INSN  = 8'h00;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        ERR   = 2'd3
    } state_t;

    // One cycle of the byte-wide load port
    typedef struct packed {
        logic       start;
        logic       valid;
        logic [7:0] data;
    } ld_req_t;

endpackage

// File: rtl/prog_mem_16x8.sv
// Instruction store: register array, one synchronous write port and one
// combinational read port so the CPU sees its fetch in the same cycle.
module prog_mem_16x8
    import prog_loader_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][DW-1:0] mem;

    // Reset fills the store with no-ops so a reset CPU runs harmlessly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= {DEPTH{DW'(NOP_INSN)}};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts a 16-byte image plus an additive checksum over a
// valid/ready port and keeps the CPU in reset until the image verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] adr,
    output logic [DW-1:0] dout,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          cpu_reset,
    output logic          load_done,
    output logic          load_err
);

    state_t        state;
    logic [AW-1:0] waddr;
    logic [DW-1:0] sum;
    ld_req_t       req;
    logic          hs;
    logic          mem_we;

    assign req    = '{start: ld_start, valid: ld_valid, data: 8'(ld_data)};
    // ld_ready is registered and state-only, so the handshake is valid & ready
    assign hs     = req.valid & ld_ready;
    // A start in the same cycle wins: the byte is dropped, not written
    assign mem_we = hs & (state == LOAD) & ~req.start;

    prog_mem_16x8 #(.AW(AW), .DW(DW)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (waddr),
        .wdata (ld_data),
        .raddr (adr),
        .rdata (dout)
    );

    // Load FSM with address counter, running checksum and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            waddr     <= '0;
            sum       <= '0;
            cpu_reset <= 1'b1;
            ld_ready  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (req.start) begin
                // Restart from any state; words already written stay put
                state     <= LOAD;
                waddr     <= '0;
                sum       <= '0;
                cpu_reset <= 1'b0;
                ld_ready  <= 1'b1;
                load_err  <= 1'b0;
            end else begin
                unique case (state)
                    RUN: ;
                    LOAD: begin
                        if (hs) begin
                            waddr <= waddr + 1'b1;
                            sum   <= sum + ld_data;
                            if (waddr == {AW{1'b1}}) state <= CHECK;
                        end
                    end
                    CHECK: begin
                        // The checksum byte is compared, never accumulated
                        if (hs) begin
                            ld_ready <= 1'b0;
                            if (ld_data == sum) begin
                                state     <= RUN;
                                cpu_reset <= 1'b1;
                                load_done <= 1'b1;
                            end else begin
                                state    <= ERR;
                                load_err <= 1'b1;
                            end
                        end
                    end
                    ERR: ;
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed vector table, hand-written corner
// sequences, then randomized traffic against a byte-level reference model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] adr = '0;
    logic [7:0] dout;
    logic       ld_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_ready, cpu_reset, load_done, load_err;

    int nchk = 0;
    int nerr = 0;
    logic [7:0] img [16];

    prog_loader #(.AW(4), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .dout      (dout),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       vl;
        logic [7:0] d;
        logic [3:0] a;
        logic       e_cr;
        logic       e_rdy;
        logic       e_done;
        logic       e_err;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic cr, input logic rdy,
                            input logic dn, input logic er);
        chk({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(cr));
        chk({tag, ".ld_ready"},  32'(ld_ready),  32'(rdy));
        chk({tag, ".load_done"}, 32'(load_done), 32'(dn));
        chk({tag, ".load_err"},  32'(load_err),  32'(er));
    endtask

    task automatic sweep(input string tag, input logic [7:0] exp [16]);
        for (int k = 0; k < 16; k++) begin
            adr = 4'(k);
            #1;
            chk($sformatf("%s.mem[%0d]", tag, k), 32'(dout), 32'(exp[k]));
        end
    endtask

    // One byte on the load port; gap inserts an idle cycle with junk data
    task automatic send(input logic [7:0] d, input bit gap);
        if (gap) begin
            ld_valid = 1'b0;
            ld_data  = 8'hEE;
            tick();
        end
        ld_valid = 1'b1;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] cs, input bit gap);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 16; k++) send(img[k], gap);
        send(cs, gap);
    endtask

    // Reference model state: bytes of the current load and their running total
    bit         m_loading, m_run, m_err, m_done;
    int         m_cnt;
    int         m_sum;
    logic [7:0] m_mem [16];

    task automatic model_reset();
        m_loading = 0; m_run = 1; m_err = 0; m_done = 0; m_cnt = 0; m_sum = 0;
        for (int k = 0; k < 16; k++) m_mem[k] = 8'h00;
    endtask

    task automatic model_step(input bit st, input bit vl, input logic [7:0] d);
        m_done = 0;
        if (st) begin
            m_loading = 1; m_run = 0; m_err = 0; m_cnt = 0; m_sum = 0;
        end else if (m_loading && vl) begin
            if (m_cnt < 16) begin
                m_mem[m_cnt] = d;
                m_sum += int'(d);
                m_cnt++;
            end else begin
                m_loading = 0;
                if (d == 8'(m_sum)) begin
                    m_run = 1; m_done = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] exp16 [16];
        int ndone;

        // 1: reset state, memory all no-ops
        tick();
        chk_outs("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) exp16[k] = 8'h00;
        sweep("rst", exp16);
        reset = 1'b1;
        tick();
        chk_outs("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0);

        // 2: table-driven good load 0x01..0x10, checksum 0x88
        tbl[0] = '{1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        for (int k = 1; k <= 16; k++)
            tbl[k] = '{1'b0, 1'b1, 8'(k), 4'(k - 1), 1'b0, 1'b1, 1'b0, 1'b0, 8'(k)};
        tbl[17] = '{1'b0, 1'b1, 8'h88, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10};
        tbl[18] = '{1'b0, 1'b0, 8'h88, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 8'h04};
        for (int i = 0; i < 19; i++) begin
            ld_start = tbl[i].st;
            ld_valid = tbl[i].vl;
            ld_data  = tbl[i].d;
            adr      = tbl[i].a;
            tick();
            chk_outs($sformatf("tbl%0d", i), tbl[i].e_cr, tbl[i].e_rdy, tbl[i].e_done, tbl[i].e_err);
            chk($sformatf("tbl%0d.dout", i), 32'(dout), 32'(tbl[i].e_dout));
        end
        ld_start = 1'b0;
        ld_valid = 1'b0;

        // 3: bad checksum parks in ERR until a new start
        for (int k = 0; k < 16; k++) img[k] = 8'(k + 1);
        do_load(8'h87, 1'b0);
        chk_outs("bad", 1'b0, 1'b0, 1'b0, 1'b1);
        ld_valid = 1'b1;
        ld_data  = 8'h88;
        tick();
        tick();
        ld_valid = 1'b0;
        chk_outs("bad_hold", 1'b0, 1'b0, 1'b0, 1'b1);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk_outs("bad_restart", 1'b0, 1'b1, 1'b0, 1'b0);

        // 4: valid on alternate cycles gives the same image and done pulse
        do_load(8'h88, 1'b1);
        chk_outs("gap_done", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) exp16[k] = 8'(k + 1);
        sweep("gap", exp16);
        tick();
        chk_outs("gap_after", 1'b1, 1'b0, 1'b0, 1'b0);

        // 5: restart after 7 bytes, then full load of 0xA1
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 7; k++) send(8'h55, 1'b0);
        for (int k = 0; k < 16; k++) img[k] = 8'hA1;
        do_load(8'h10, 1'b0);
        chk_outs("rst7_done", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) exp16[k] = 8'hA1;
        sweep("rst7", exp16);

        // 6: async reset mid-load, then start+valid together drops the byte
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 9; k++) send(8'h33, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_outs("areset_now", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_outs("areset", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) exp16[k] = 8'h00;
        sweep("areset", exp16);
        reset = 1'b1;
        tick();
        adr      = 4'd0;
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        tick();
        ld_start = 1'b0;
        chk_outs("start_valid", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_valid.dout", 32'(dout), 32'h00);
        ld_data = 8'h12;
        tick();
        ld_valid = 1'b0;
        chk("start_valid.first", 32'(dout), 32'h12);

        // Randomized traffic against the reference model
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        model_reset();
        ndone = 0;
        for (int c = 0; c < 3000; c++) begin
            logic       st, vl;
            logic [7:0] d;
            st = ($urandom_range(0, 59) == 0) || (!m_loading && $urandom_range(0, 7) == 0);
            vl = $urandom_range(0, 1) == 1;
            d  = 8'($urandom);
            if (m_loading && m_cnt == 16 && $urandom_range(0, 3) != 0) d = 8'(m_sum);
            ld_start = st;
            ld_valid = vl;
            ld_data  = d;
            adr      = 4'($urandom_range(0, 15));
            model_step(st, vl, d);
            tick();
            if (m_done) ndone++;
            chk_outs("rnd", m_run, m_loading, m_done, m_err);
            chk("rnd.dout", 32'(dout), 32'(m_mem[adr]));
        end
        ld_start = 1'b0;
        ld_valid = 1'b0;
        chk("rnd.some_loads_verified", 32'(ndone > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
